// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between fetch and decode: 32-bit and RVC immediates, format and pc-relative target.
// Latency 1 cycle; single output register, in_ready = !out_valid || out_ready, flush drops held entry and same-cycle input.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_RVC = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_is_rvc,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM32  = 5'b00110;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic [2:0]      w_fmt;
  logic            w_is_rvc;
  logic            w_illegal;
  logic            w_use_tgt;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_fmt;
  logic            r_is_rvc;
  logic            r_illegal;
  logic [XLEN-1:0] r_target;

  // Every immediate fits a 32-bit signed value (C.LW/C.SW offsets have bit 31 clear),
  // so decode once at 32 bits and sign-extend to XLEN afterwards.
  always_comb begin
    w_imm32   = '0;
    w_fmt     = FMT_NONE;
    w_is_rvc  = 1'b0;
    w_illegal = 1'b0;
    w_use_tgt = 1'b0;
    if (inst[1:0] == 2'b11) begin
      if (inst[4:2] == 3'b111) begin
        w_illegal = 1'b1;
      end else begin
        case (inst[6:2])
          OP_LOAD, OP_IMM, OP_JALR, OP_IMM32: begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{inst[31]}}, inst[31:20]};
          end
          OP_STORE: begin
            w_fmt   = FMT_S;
            w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
          end
          OP_BRANCH: begin
            w_fmt     = FMT_B;
            w_imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            w_use_tgt = 1'b1;
          end
          OP_LUI, OP_AUIPC: begin
            w_fmt     = FMT_U;
            w_imm32   = {inst[31:12], 12'b0};
            w_use_tgt = (inst[6:2] == OP_AUIPC);
          end
          OP_JAL: begin
            w_fmt     = FMT_J;
            w_imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            w_use_tgt = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (SUPPORT_RVC) begin
      w_is_rvc = 1'b1;
      case ({inst[15:13], inst[1:0]})
        5'b000_01, 5'b010_01: begin
          w_fmt   = FMT_I;
          w_imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
        end
        5'b010_00: begin
          w_fmt   = FMT_I;
          w_imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
        end
        5'b110_00: begin
          w_fmt   = FMT_S;
          w_imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
        end
        5'b101_01: begin
          w_fmt     = FMT_J;
          w_imm32   = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                       inst[2], inst[11], inst[5:3], 1'b0};
          w_use_tgt = 1'b1;
        end
        5'b110_01, 5'b111_01: begin
          w_fmt     = FMT_B;
          w_imm32   = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
          w_use_tgt = 1'b1;
        end
        default: ;
      endcase
    end else begin
      w_illegal = 1'b1;
    end
  end

  assign w_imm    = XLEN'($signed(w_imm32));
  assign w_target = w_use_tgt ? (pc + w_imm) : '0;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_imm     <= '0;
      r_fmt     <= FMT_NONE;
      r_is_rvc  <= 1'b0;
      r_illegal <= 1'b0;
      r_target  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_imm     <= w_imm;
      r_fmt     <= w_fmt;
      r_is_rvc  <= w_is_rvc;
      r_illegal <= w_illegal;
      r_target  <= w_target;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_imm     = r_imm;
  assign out_fmt     = r_fmt;
  assign out_is_rvc  = r_is_rvc;
  assign out_illegal = r_illegal;
  assign out_target  = r_target;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Decodes the sign-extended immediate from one 32-bit or compressed 16-bit instruction per transfer, generalised to XLEN.
- Classifies the format and precomputes the pc-relative target for branch, jump and auipc instructions.
- Sits between fetch and decode. Uses a valid/ready input and output with a single output register and flush.

Parameters:
- XLEN, 32, datapath width (32 or 64). Sets the immediate, pc and target width.
- SUPPORT_RVC, 1, when 1 decode the compressed subset; when 0 any inst[1:0]!=2'b11 is illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop the held entry and any same-cycle input
- in_valid  in  1  input transfer request
- in_ready  out  1  stage can accept input
- inst  in  32  instruction; compressed instructions in inst[15:0]
- pc  in  XLEN  address of inst
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts output
- out_imm  out  XLEN  sign/zero-extended immediate
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- out_is_rvc  out  1  entry was a 16-bit instruction
- out_illegal  out  1  unsupported length or encoding
- out_target  out  XLEN  pc+out_imm for B, J and AUIPC; 0 otherwise

Behaviour:
- Reset: all outputs 0 asynchronously (out_valid=0, out_imm=0, out_fmt=0, out_target=0, flags=0). in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational). Full throughput with 1-cycle latency.
- Input accepted when in_valid && in_ready && !flush. Results are registered on that edge.
- Output retires when out_valid && out_ready.
- Accept and retire in the same cycle: the new entry replaces the old one and out_valid stays 1.
- Back-pressure (out_valid && !out_ready): all output fields hold stable and in_ready=0.
- flush: the next edge clears out_valid and ignores the input. flush wins over accept.
- Reset mid-transfer discards the entry.
- 32-bit decode is keyed on inst[6:2]; sign bit is inst[31]; results are extended to XLEN.
  - LOAD, OP_IMM, JALR, OP_IMM_32 -> I: sext(inst[31:20]).
  - STORE -> S: sext({inst[31:25], inst[11:7]}).
  - BRANCH -> B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - LUI, AUIPC -> U: sext({inst[31:12], 12'b0}). Bits above 31 copy inst[31] when XLEN=64.
  - JAL -> J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Other opcodes -> fmt NONE, imm 0, not illegal.
  - inst[4:2]==3'b111 with inst[1:0]==2'b11 (instruction longer than 32 bits) -> illegal, fmt NONE, imm 0.
- RVC decode (SUPPORT_RVC=1) is keyed on {inst[15:13], inst[1:0]}:
  - C.ADDI (000,01) and C.LI (010,01) -> I: sext({inst[12], inst[6:2]}).
  - C.LW (010,00) -> I; C.SW (110,00) -> S. Both zero-extended: {inst[5], inst[12:10], inst[6], 2'b00}.
  - C.J (101,01) -> J: sext({inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 0}).
  - C.BEQZ (110,01) and C.BNEZ (111,01) -> B: sext({inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 0}).
  - Other 16-bit encodings -> fmt NONE, imm 0, not illegal. out_is_rvc=1 in every case.
- SUPPORT_RVC=0 and inst[1:0]!=2'b11 -> out_illegal=1, fmt NONE, imm 0, out_is_rvc=0.
- out_target: pc+imm modulo 2^XLEN (wraps, no overflow flag), produced only for fmt B, J and AUIPC. JALR, C.LW and all other formats give 0.

Test Plan:
- XLEN=32: inst=0x0080006F (JAL +8), pc=0x100, out_ready=1 -> next cycle out_valid=1, fmt J, imm=0x8, target=0x108.
- XLEN=32: inst=0xFE000EE3 (BEQ -4), pc=0x100 -> fmt B, imm=0xFFFFFFFC, target=0xFC. With pc=0x0 -> target=0xFFFFFFFC (wrap).
- XLEN=64: inst=0x800000B7 (LUI) -> fmt U, imm=0xFFFFFFFF80000000, target=0.
- C.LI x1,-1: inst=0x000050FD -> is_rvc=1, fmt I, imm all ones. With SUPPORT_RVC=0 -> illegal=1, imm=0.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 -> one retire and next accept in the same cycle; no entry lost or duplicated over a 100-instruction random stream checked against a reference model.
- flush with in_valid=1 while holding an entry -> out_valid=0 next cycle, input dropped. Deassert rst_n mid-stream -> outputs 0 immediately, asynchronously.
